count_pwm_gen: RTL and testbench

//   PWM generator that consumes the free-running 4-bit value from the up/down

---
 rtl/count_pwm_gen_if.sv | 22 ++
 rtl/count_pwm_gen.sv | 136 +++++++++++++
 tb/tb_count_pwm_gen.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_pwm_gen_if.sv
// Duty-update handshake bundle for count_pwm_gen.
// The master offers a requested duty value with duty_valid. The slave answers
// with duty_ready while its shadow register is free.
interface count_pwm_gen_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH:0] duty_in;
    logic           duty_valid;
    logic           duty_ready;

    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );
endinterface

// File: rtl/count_pwm_gen.sv
// PWM generator driven by an external free-running counter value.
// Duty updates land in a shadow register and are moved into the active duty
// only on a detected period boundary, so a period is never cut short or
// stretched by an update.
module count_pwm_gen #(
    parameter int WIDTH      = 4,
    parameter bit COUNT_DOWN = 1'b0,
    parameter bit POLARITY   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             en,
    count_pwm_gen_if.slave   duty_if,
    output logic             pwm_out,
    output logic             period_start,
    output logic             update_ack
);

    localparam logic [WIDTH:0] DUTY_MAX = {1'b1, {WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] cnt_prev_reg;
    logic [WIDTH-1:0] phase;
    logic [WIDTH:0]   active_duty_reg;
    logic [WIDTH:0]   shadow_duty_reg;
    logic [WIDTH:0]   duty_clamped;
    logic [WIDTH:0]   eff_duty;
    logic             pending_reg;
    logic             wrap;
    logic             capture;
    logic             apply;
    logic             pwm_active_next;
    logic             pwm_out_reg;
    logic             period_start_reg;
    logic             update_ack_reg;

    // A down-counting source is mirrored so that phase always runs upward from 0.
    assign phase = COUNT_DOWN ? ~cnt_in : cnt_in;

    // A boundary needs phase 0 and a changed count. A source parked at the
    // start value therefore does not retrigger on every cycle.
    assign wrap = (phase == '0) && (cnt_prev_reg != cnt_in);

    assign duty_if.duty_ready = ~pending_reg;
    assign capture            = duty_if.duty_valid && ~pending_reg;
    assign apply              = wrap && pending_reg;
    assign duty_clamped       = (duty_if.duty_in > DUTY_MAX) ? DUTY_MAX : duty_if.duty_in;

    // The period that begins on this wrap already uses the freshly applied duty.
    assign eff_duty = apply ? shadow_duty_reg : active_duty_reg;

    // Track the counter and move duty through shadow -> active.
    // Capture and apply are exclusive because capture requires an empty shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_prev_reg    <= '0;
            active_duty_reg <= '0;
            shadow_duty_reg <= '0;
            pending_reg     <= 1'b0;
        end else begin
            cnt_prev_reg <= cnt_in;
            if (apply) begin
                active_duty_reg <= shadow_duty_reg;
                pending_reg     <= 1'b0;
            end
            if (capture) begin
                shadow_duty_reg <= duty_clamped;
                pending_reg     <= 1'b1;
            end
        end
    end

    // State register of the enable/arming sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, and whether the registered output is active next cycle.
    always_comb begin
        state_next      = state_reg;
        pwm_active_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (wrap) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        pwm_active_next = (state_next == RUN) && ({1'b0, phase} < eff_duty);
    end

    // Output registers: each output lags cnt_in by exactly one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out_reg      <= ~POLARITY;
            period_start_reg <= 1'b0;
            update_ack_reg   <= 1'b0;
        end else begin
            pwm_out_reg      <= pwm_active_next ? POLARITY : ~POLARITY;
            period_start_reg <= wrap;
            update_ack_reg   <= apply;
        end
    end

    assign pwm_out      = pwm_out_reg;
    assign period_start = period_start_reg;
    assign update_ack   = update_ack_reg;

endmodule

// File: tb/tb_count_pwm_gen.sv
// Bench for count_pwm_gen. It runs an up-counting, active-high instance and a
// down-counting, active-low instance side by side. Each instance is compared
// every cycle against a period-level behavioural model.
module tb_count_pwm_gen;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [1:0][W-1:0]   cnt;
    logic [1:0]          en;
    logic [1:0]          dv;
    logic [1:0][W:0]     dd;
    logic [1:0]          rdy, pwm, ps, ack;
    logic                pwm_u, ps_u, ack_u, pwm_d, ps_d, ack_d;
    logic                auto_cnt;

    count_pwm_gen_if #(.WIDTH(W)) dif0 ();
    count_pwm_gen_if #(.WIDTH(W)) dif1 ();

    assign dif0.duty_valid = dv[0];
    assign dif0.duty_in    = dd[0];
    assign dif1.duty_valid = dv[1];
    assign dif1.duty_in    = dd[1];
    assign rdy = {dif1.duty_ready, dif0.duty_ready};
    assign pwm = {pwm_d, pwm_u};
    assign ps  = {ps_d, ps_u};
    assign ack = {ack_d, ack_u};

    count_pwm_gen #(.WIDTH(W), .COUNT_DOWN(1'b0), .POLARITY(1'b1)) dut_up (
        .clk(clk), .rst(rst), .cnt_in(cnt[0]), .en(en[0]), .duty_if(dif0),
        .pwm_out(pwm_u), .period_start(ps_u), .update_ack(ack_u)
    );

    count_pwm_gen #(.WIDTH(W), .COUNT_DOWN(1'b1), .POLARITY(1'b0)) dut_dn (
        .clk(clk), .rst(rst), .cnt_in(cnt[1]), .en(en[1]), .duty_if(dif1),
        .pwm_out(pwm_d), .period_start(ps_d), .update_ack(ack_d)
    );

    // ---------------- reference model ----------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int m_prev[2], m_mode[2], m_active[2], m_shadow[2];
    bit m_has[2];
    bit e_pwm[2], e_ps[2], e_ack[2], e_rdy[2];

    function automatic bit pol(int i);
        return (i == 0);
    endfunction

    function automatic bit down(int i);
        return (i == 1);
    endfunction

    task automatic model_reset(int i);
        m_prev[i]   = 0;
        m_mode[i]   = 0;
        m_active[i] = 0;
        m_shadow[i] = 0;
        m_has[i]    = 1'b0;
        e_pwm[i]    = !pol(i);
        e_ps[i]     = 1'b0;
        e_ack[i]    = 1'b0;
        e_rdy[i]    = 1'b1;
    endtask

    // mode: 0 disabled, 1 enabled but waiting for a period start, 2 generating.
    task automatic model_clock(int i);
        int  c, ph, d;
        bit  boundary;
        c        = int'(cnt[i]);
        ph       = down(i) ? (15 - c) : c;
        boundary = (ph == 0) && (c != m_prev[i]);
        e_ack[i] = boundary && m_has[i];
        if (e_ack[i]) begin
            m_active[i] = m_shadow[i];
            m_has[i]    = 1'b0;
        end else if (dv[i] && !m_has[i]) begin
            d           = int'(dd[i]);
            m_shadow[i] = (d > 16) ? 16 : d;
            m_has[i]    = 1'b1;
        end
        if (!en[i])                          m_mode[i] = 0;
        else if (m_mode[i] == 0)             m_mode[i] = 1;
        else if (m_mode[i] == 1 && boundary) m_mode[i] = 2;
        e_pwm[i]  = (m_mode[i] == 2 && ph < m_active[i]) ? pol(i) : !pol(i);
        e_ps[i]   = boundary;
        e_rdy[i]  = !m_has[i];
        m_prev[i] = c;
    endtask

    task automatic chk(string name, int i, logic got, logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s[%0d] cyc %0d got %0b want %0b", name, i, cyc, got, want);
        end
    endtask

    task automatic chk_int(string name, int i, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s[%0d] cyc %0d got %0d want %0d", name, i, cyc, got, want);
        end
    endtask

    // One clock: the model sees the same inputs as the DUT at the rising edge.
    // Outputs are compared on the falling edge. Afterwards the source drops
    // valid once a transfer has happened, and the counters advance.
    task automatic step();
        bit acc [2];
        for (int i = 0; i < 2; i++) acc[i] = dv[i] && rdy[i] && !rst;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_clock(i);
        end
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            chk("pwm_out", i, pwm[i], e_pwm[i]);
            chk("period_start", i, ps[i], e_ps[i]);
            chk("update_ack", i, ack[i], e_ack[i]);
            chk("duty_ready", i, rdy[i], e_rdy[i]);
            if (acc[i]) dv[i] = 1'b0;
        end
        if (auto_cnt) begin
            cnt[0] = W'(cnt[0] + 1'b1);
            cnt[1] = W'(cnt[1] - 1'b1);
        end
    endtask

    // Count active cycles over one full period, starting at the current cycle.
    task automatic count_period(int i, int exp_high, int exp_acks);
        int n, a;
        n = (pwm[i] == pol(i)) ? 1 : 0;
        a = 0;
        repeat (15) begin
            step();
            if (pwm[i] == pol(i)) n++;
            if (ack[i]) a++;
        end
        $display("dut%0d period: high %0d (want %0d), extra acks %0d", i, n, exp_high, a);
        chk_int("period_high", i, n, exp_high);
        chk_int("period_acks", i, a, exp_acks);
    endtask

    // Wait (bounded) for the update_ack of a load, then measure that period.
    task automatic measure_period(int i, int exp_high);
        int k;
        k = 0;
        while (!ack[i] && k < 64) begin
            step();
            k++;
        end
        checks++;
        if (!ack[i]) begin
            errors++;
            $display("FAIL ack_timeout[%0d] cyc %0d got no update_ack want pulse", i, cyc);
        end else begin
            count_period(i, exp_high, 0);
        end
    endtask

    typedef struct {
        logic [W:0] duty;
        int         high;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int acks;
        tbl[0] = '{duty: 5'd6,  high: 6};
        tbl[1] = '{duty: 5'd16, high: 16};
        tbl[2] = '{duty: 5'd0,  high: 0};
        tbl[3] = '{duty: 5'd31, high: 16};
        tbl[4] = '{duty: 5'd1,  high: 1};
        tbl[5] = '{duty: 5'd15, high: 15};
        tbl[6] = '{duty: 5'd17, high: 16};

        rst      = 1'b1;
        en       = '0;
        dv       = '0;
        dd       = '0;
        cnt[0]   = '0;
        cnt[1]   = 4'd15;
        auto_cnt = 1'b0;
        for (int i = 0; i < 2; i++) model_reset(i);
        step();
        step();

        // Up-count source: duty loaded before the first wrap, then more loads from the table.
        rst      = 1'b0;
        auto_cnt = 1'b1;
        en[0]    = 1'b1;
        for (int t = 0; t < 7; t++) begin
            dv[0] = 1'b1;
            dd[0] = tbl[t].duty;
            $display("load duty %0d on dut0", tbl[t].duty);
            measure_period(0, tbl[t].high);
        end

        // Second request while one is outstanding is refused until the apply.
        dv[0] = 1'b1;
        dd[0] = 5'd4;
        step();
        dv[0] = 1'b1;
        dd[0] = 5'd12;
        repeat (3) step();
        chk("ready_while_pending", 0, rdy[0], 1'b0);
        measure_period(0, 4);
        measure_period(0, 12);

        // Capture in the exact wrap cycle: the current period keeps the old duty.
        dv[0] = 1'b1;
        dd[0] = 5'd8;
        step();
        chk("wrap_capture_ps", 0, ps[0], 1'b1);
        count_period(0, 12, 0);
        measure_period(0, 8);

        // Dropping en mid-pulse truncates the output on the next clock.
        repeat (3) step();
        chk("pwm_before_drop", 0, pwm[0], 1'b1);
        en[0] = 1'b0;
        step();
        chk("pwm_after_drop", 0, pwm[0], 1'b0);

        // Reset with an update pending discards it and acts immediately.
        en[0] = 1'b1;
        dv[0] = 1'b1;
        dd[0] = 5'd5;
        step();
        chk("pending_before_rst", 0, rdy[0], 1'b0);
        dv[0] = 1'b0;
        rst   = 1'b1;
        #1;
        chk("rst_ready", 0, rdy[0], 1'b1);
        chk("rst_pwm", 0, pwm[0], 1'b0);
        step();
        rst  = 1'b0;
        acks = 0;
        repeat (40) begin
            step();
            if (ack[0]) acks++;
        end
        chk_int("acks_after_rst", 0, acks, 0);

        // Down-count source, active-low output, duty 3.
        en[1] = 1'b1;
        dv[1] = 1'b1;
        dd[1] = 5'd3;
        $display("load duty 3 on dut1");
        measure_period(1, 3);

        // Randomised traffic on both instances against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 39) == 0) en[i] = ~en[i];
                if (!dv[i] && $urandom_range(0, 5) == 0) begin
                    dv[i] = 1'b1;
                    dd[i] = (W+1)'($urandom_range(0, 31));
                end
                if ($urandom_range(0, 49) == 0) cnt[i] = W'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc %0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
